// File: rtl/bus_sequencer.sv
// Slot scheduler for the shared 16 MHz memory bus: EXT, CPU, VRAM, VROM slots of 4 ticks each.
// Owner is fixed at slot entry; phase strobes and character-clock enable run regardless of owner.
module bus_sequencer #(
    parameter bit         EXT_REUSE  = 1'b1,
    parameter logic [3:0] CCLK_PHASE = 4'd15
) (
    input  logic       clk16_i,
    input  logic       reset_ni,
    input  logic       video_en_i,
    input  logic       ext_req_i,
    output logic       ext_grant_o,
    output logic       ext_done_o,
    output logic       setup_clk_o,
    output logic       strobe_clk_o,
    output logic       cpu_en_o,
    output logic       vram_en_o,
    output logic       vrom_en_o,
    output logic       cclk_en_o,
    output logic [3:0] phase_o
);

    typedef enum logic [2:0] {
        OWN_IDLE,
        OWN_EXT,
        OWN_CPU,
        OWN_VRAM,
        OWN_VROM
    } owner_e;

    logic       started_q;
    logic [3:0] phase_q, phase_d;
    owner_e     owner_q, owner_d;
    logic       vid_q, vid_d;

    logic ext_grant_q, ext_grant_d;
    logic ext_done_q, ext_done_d;
    logic setup_q, setup_d;
    logic strobe_q, strobe_d;
    logic cpu_en_q, cpu_en_d;
    logic vram_en_q, vram_en_d;
    logic vrom_en_q, vrom_en_d;
    logic cclk_q, cclk_d;

    logic ext_reuse_ok;
    assign ext_reuse_ok = EXT_REUSE && ext_req_i;

    // State and output registers
    always_ff @(posedge clk16_i or negedge reset_ni) begin
        if (!reset_ni) begin
            started_q   <= 1'b0;
            phase_q     <= 4'd0;
            owner_q     <= OWN_IDLE;
            vid_q       <= 1'b0;
            ext_grant_q <= 1'b0;
            ext_done_q  <= 1'b0;
            setup_q     <= 1'b0;
            strobe_q    <= 1'b0;
            cpu_en_q    <= 1'b0;
            vram_en_q   <= 1'b0;
            vrom_en_q   <= 1'b0;
            cclk_q      <= 1'b0;
        end else begin
            started_q   <= 1'b1;
            phase_q     <= phase_d;
            owner_q     <= owner_d;
            vid_q       <= vid_d;
            ext_grant_q <= ext_grant_d;
            ext_done_q  <= ext_done_d;
            setup_q     <= setup_d;
            strobe_q    <= strobe_d;
            cpu_en_q    <= cpu_en_d;
            vram_en_q   <= vram_en_d;
            vrom_en_q   <= vrom_en_d;
            cclk_q      <= cclk_d;
        end
    end

    // First edge after reset release enters phase 0 rather than skipping it
    always_comb begin
        phase_d = started_q ? phase_q + 4'd1 : 4'd0;
        owner_d = owner_q;
        vid_d   = vid_q;
        if (phase_d[1:0] == 2'd0) begin
            unique case (phase_d[3:2])
                2'd0: owner_d = ext_req_i ? OWN_EXT : OWN_IDLE;
                2'd1: owner_d = OWN_CPU;
                2'd2: begin
                    vid_d = video_en_i;
                    if (video_en_i)        owner_d = OWN_VRAM;
                    else if (ext_reuse_ok) owner_d = OWN_EXT;
                    else                   owner_d = OWN_IDLE;
                end
                2'd3: begin
                    if (vid_q)             owner_d = OWN_VROM;
                    else if (ext_reuse_ok) owner_d = OWN_EXT;
                    else                   owner_d = OWN_IDLE;
                end
                default: owner_d = OWN_IDLE;
            endcase
        end
    end

    always_comb begin
        setup_d     = (phase_d[1:0] == 2'd0) || (phase_d[1:0] == 2'd1);
        strobe_d    = (phase_d[1:0] == 2'd1) || (phase_d[1:0] == 2'd2);
        cclk_d      = (phase_d == CCLK_PHASE);
        ext_grant_d = (owner_d == OWN_EXT);
        cpu_en_d    = (owner_d == OWN_CPU);
        vram_en_d   = (owner_d == OWN_VRAM);
        vrom_en_d   = (owner_d == OWN_VROM);
        ext_done_d  = (owner_d == OWN_EXT) && (phase_d[1:0] == 2'd2);
    end

    assign ext_grant_o  = ext_grant_q;
    assign ext_done_o   = ext_done_q;
    assign setup_clk_o  = setup_q;
    assign strobe_clk_o = strobe_q;
    assign cpu_en_o     = cpu_en_q;
    assign vram_en_o    = vram_en_q;
    assign vrom_en_o    = vrom_en_q;
    assign cclk_en_o    = cclk_q;
    assign phase_o      = phase_q;

endmodule
